// File: rtl/program_loader_if.sv
// Byte-stream handshake between the image source and program_loader.
// The master drives data/valid; the slave (loader) drives ready.
interface program_loader_if #(
    parameter int DATAWIDTH = 8
);
    logic [DATAWIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/program_loader.sv
// program_loader: boot-time stage that streams a program image into the
// memory unit and then releases the RISC core by raising cpu_run.
// Stream: length byte L (0 means 2^ADDR_WIDTH words), then the data bytes.
// Optional macro PROGRAM_LOADER_CHECKSUM_EN appends a checksum byte that
// must make (L + sum(D) + C) wrap to zero, otherwise err is raised.
module program_loader #(
    parameter int DATAWIDTH  = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    program_loader_if.slave       s_if,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATAWIDTH-1:0]  mem_data,
    output logic                  cpu_run,
    output logic                  busy,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   load_count
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_LOAD = 3'd2,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ST_CHK  = 3'd3,
`endif
        ST_RUN  = 3'd4
    } state_t;

    // Length byte 0 encodes a full 2^ADDR_WIDTH image.
    localparam logic [ADDR_WIDTH:0] FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   load_count_q;
    logic                  mem_write_q;
    logic [ADDR_WIDTH-1:0] mem_address_q;
    logic [DATAWIDTH-1:0]  mem_data_q;
    logic                  cpu_run_q;
    logic                  xfer_s;
    logic                  last_s;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic                  err_q;
    logic [DATAWIDTH-1:0]  sum_q;
    logic [DATAWIDTH-1:0]  sum_next_s;

    assign sum_next_s = sum_q + s_if.in_data;
    assign err        = err_q;
    assign s_if.in_ready = (state_q == ST_LEN) || (state_q == ST_LOAD) || (state_q == ST_CHK);
`else
    assign err        = 1'b0;
    assign s_if.in_ready = (state_q == ST_LEN) || (state_q == ST_LOAD);
`endif

    assign busy        = s_if.in_ready;
    assign xfer_s      = s_if.in_valid && s_if.in_ready;
    assign last_s      = ((load_count_q + CNT_ONE) == len_q);
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign cpu_run     = cpu_run_q;
    assign load_count  = load_count_q;

    // Loader state machine with registered write strobe and core release.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            addr_q        <= '0;
            load_count_q  <= '0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            cpu_run_q     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            err_q         <= 1'b0;
            sum_q         <= '0;
`endif
        end else begin
            mem_write_q <= 1'b0;
            cpu_run_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_LEN;
                        load_count_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        err_q        <= 1'b0;
                        sum_q        <= '0;
`endif
                    end
                end
                ST_LEN: begin
                    if (xfer_s) begin
                        if (s_if.in_data == '0) begin
                            len_q <= FULL_LEN;
                        end else begin
                            len_q <= (ADDR_WIDTH+1)'(s_if.in_data);
                        end
                        addr_q  <= '0;
                        state_q <= ST_LOAD;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum_q   <= sum_next_s;
`endif
                    end
                end
                ST_LOAD: begin
                    if (xfer_s) begin
                        mem_write_q   <= 1'b1;
                        mem_address_q <= addr_q;
                        mem_data_q    <= s_if.in_data;
                        addr_q        <= addr_q + ADDR_ONE;
                        load_count_q  <= load_count_q + CNT_ONE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum_q         <= sum_next_s;
                        if (last_s) begin
                            state_q <= ST_CHK;
                        end
`else
                        if (last_s) begin
                            state_q <= ST_RUN;
                        end
`endif
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (xfer_s) begin
                        if (sum_next_s == '0) begin
                            state_q <= ST_RUN;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
`endif
                ST_RUN: begin
                    if (start) begin
                        state_q      <= ST_LEN;
                        load_count_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        err_q        <= 1'b0;
                        sum_q        <= '0;
`endif
                    end else begin
                        cpu_run_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: the stimulus pushes expected memory
// writes into a queue, a negedge monitor pops and compares each write.
module tb_program_loader;

    logic        clk;
    logic        clr;
    logic        start;
    logic        mem_write;
    logic [7:0]  mem_address;
    logic [7:0]  mem_data;
    logic        cpu_run;
    logic        busy;
    logic        err;
    logic [8:0]  load_count;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic [15:0] exp_q[$];
    int          wr_cycles[$];
    logic [7:0]  img[$];

    program_loader_if #(.DATAWIDTH(8)) ifc ();

    program_loader #(.DATAWIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .s_if       (ifc.slave),
        .mem_write  (mem_write),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .err        (err),
        .load_count (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mem_write) begin
            wr_cycles.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%02h data=%02h, required no write", mem_address, mem_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({mem_address, mem_data} !== e) begin
                    errors++;
                    $display("FAIL write: got addr=%02h data=%02h, required addr=%02h data=%02h",
                             mem_address, mem_data, e[15:8], e[7:0]);
                end
            end
            checks++;
            if (cpu_run !== 1'b0) begin
                errors++;
                $display("FAIL run_during_write: got cpu_run=%0b, required 0", cpu_run);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_count", {23'd0, load_count}, 32'd0);
        chk("start_err", {31'd0, err}, 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            ifc.in_valid = 1'b0;
            ifc.in_data  = 8'hEE;
            @(posedge clk); #1;
            chk("ready_gap", {31'd0, ifc.in_ready}, 32'd1);
        end
        ifc.in_valid = 1'b1;
        ifc.in_data  = b;
        t = 0;
        while (!ifc.in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got in_ready=0, required 1");
        end
        @(posedge clk); #1;
    endtask

    // Sends length byte, img[] data (and checksum when enabled); queues writes.
    task automatic send_image(input logic [7:0] len, input int gap, input bit bad_ck);
        logic [7:0] sum;
        sum = len;
        send_byte(len, 0);
        for (int i = 0; i < img.size(); i++) begin
            exp_q.push_back({i[7:0], img[i]});
            sum = sum + img[i];
            send_byte(img[i], gap);
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'h00 - sum + {7'd0, bad_ck}, 0);
`else
        if (bad_ck) sum = 8'h00;
`endif
        ifc.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b0;
        start = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;
        repeat (2) @(posedge clk); #1;
        chk("reset_outs", {in_ready_w(), mem_write, mem_address, mem_data, cpu_run, busy, err, load_count}, 32'd0);
        clr = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", {31'd0, ifc.in_ready}, 32'd0);

        // Continuous 03,A1,B2,C3
        img = '{8'hA1, 8'hB2, 8'hC3};
        wr_cycles.delete();
        do_start();
        send_image(8'h03, 0, 1'b0);
        chk("run_late", {31'd0, cpu_run}, 32'd0);
        @(posedge clk); #1;
        chk("run_rise", {31'd0, cpu_run}, 32'd1);
        chk("count3", {23'd0, load_count}, 32'd3);
        chk("busy_run", {31'd0, busy}, 32'd0);
        chk("nwrites", wr_cycles.size(), 32'd3);
        if (wr_cycles.size() == 3) chk("consecutive", wr_cycles[2] - wr_cycles[0], 32'd2);

        // Same image with 2-cycle gaps, restarted from RUN
        wr_cycles.delete();
        do_start();
        chk("run_fall", {31'd0, cpu_run}, 32'd0);
        send_image(8'h03, 2, 1'b0);
        @(posedge clk); #1;
        chk("gap_run", {31'd0, cpu_run}, 32'd1);
        chk("gap_count", {23'd0, load_count}, 32'd3);
        chk("gap_nwrites", wr_cycles.size(), 32'd3);

        // Full 256-word image, data = address
        img.delete();
        for (int i = 0; i < 256; i++) img.push_back(i[7:0]);
        do_start();
        send_image(8'h00, 0, 1'b0);
        @(posedge clk); #1;
        chk("full_count", {23'd0, load_count}, 32'd256);
        chk("full_addr", {24'd0, mem_address}, 32'hFF);
        chk("full_data", {24'd0, mem_data}, 32'hFF);
        chk("full_run", {31'd0, cpu_run}, 32'd1);

        // Reset after 2 of 4 data bytes
        do_start();
        send_byte(8'h04, 0);
        exp_q.push_back({8'h00, 8'h11});
        send_byte(8'h11, 0);
        exp_q.push_back({8'h01, 8'h22});
        send_byte(8'h22, 0);
        ifc.in_valid = 1'b0;
        @(negedge clk); #2;
        clr = 1'b0;
        #1;
        chk("abort_outs", {in_ready_w(), mem_write, mem_address, mem_data, cpu_run, busy, err, load_count}, 32'd0);
        #3;
        clr = 1'b1;
        @(posedge clk); #1;
        chk("abort_run", {31'd0, cpu_run}, 32'd0);
        img = '{8'h5A};
        do_start();
        send_image(8'h01, 0, 1'b0);
        @(posedge clk); #1;
        chk("after_abort_run", {31'd0, cpu_run}, 32'd1);
        chk("after_abort_cnt", {23'd0, load_count}, 32'd1);

        // Restart from RUN with 01,77
        img = '{8'h77};
        do_start();
        chk("rerun_fall", {31'd0, cpu_run}, 32'd0);
        send_image(8'h01, 0, 1'b0);
        @(posedge clk); #1;
        chk("rerun_rise", {31'd0, cpu_run}, 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // 02,10,20,CE good; 02,10,20,CF bad
        img = '{8'h10, 8'h20};
        do_start();
        send_image(8'h02, 0, 1'b0);
        @(posedge clk); #1;
        chk("ck_good_run", {31'd0, cpu_run}, 32'd1);
        chk("ck_good_err", {31'd0, err}, 32'd0);
        do_start();
        send_image(8'h02, 0, 1'b1);
        chk("ck_bad_err", {31'd0, err}, 32'd1);
        chk("ck_bad_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("ck_bad_run", {31'd0, cpu_run}, 32'd0);
        chk("ck_bad_ready", {31'd0, ifc.in_ready}, 32'd0);
`else
        chk("err_tied", {31'd0, err}, 32'd0);
`endif

        repeat (3) @(posedge clk); #1;
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic in_ready_w();
        return ifc.in_ready;
    endfunction

endmodule
